tape_cache_ctrl: RTL

TAPE_CACHE_CTRL -- requirements
Module: tape_cache_ctrl

---
 rtl/tape_cache_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/tape_cache_ctrl.sv
// tape_cache_ctrl
//   Arbitrates a single-port tape cache RAM between three users:
//     - the HPS tape download, which always wins and writes straight through
//     - a cassette player that reads one byte per request
//     - a recorder that writes one byte per request (optionally write-protected)
//   It also keeps track of the tape image extent (tape_end) and validity
//   (tape_loaded), and emits a rewind pulse when a new download starts.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   dl_active/dl_wr/dl_addr/dl_data
//                                download window, byte strobe, address, data
//   play_req/play_addr           player read request (level) and address
//   play_ack/play_data           one-cycle read completion, read byte
//   rec_req/rec_addr/rec_data    recorder write request (level), address, data
//   rec_ack                      one-cycle write completion
//   write_protect                suppresses the recorder RAM write
//   mem_addr/mem_wdata/mem_we    cache RAM port
//   mem_q                        cache RAM read data (one-cycle latency)
//   tape_end                     last valid tape byte address
//   tape_loaded                  cache holds a valid image
//   rewind                       one-cycle pulse after dl_active rises
//   fsm_state                    debug view of the FSM: 0=IDLE 1=DL 2=RD_WAIT 3=WR
//
// Handshake (player and recorder): req is a level held until ack. ack is a
// one-cycle pulse. The requester drops req in the cycle after ack, so a req
// seen high during its own ack cycle belongs to the finished transfer and is
// ignored; a req still high one cycle after ack is a new request.

module tape_cache_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [15:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        play_req,
  input  logic [15:0] play_addr,
  output logic        play_ack,
  output logic [7:0]  play_data,
  input  logic        rec_req,
  input  logic [15:0] rec_addr,
  input  logic [7:0]  rec_data,
  output logic        rec_ack,
  input  logic        write_protect,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_q,
  output logic [15:0] tape_end,
  output logic        tape_loaded,
  output logic        rewind,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DL      = 2'd1,
    RD_WAIT = 2'd2,
    WR      = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        rr_rec_q;      // 1: recorder wins the next contended grant
  logic        dl_active_q;
  logic        written_q;     // a dl_wr happened in the current download
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;

  logic        play_pend;
  logic        rec_pend;
  logic        grant_play;
  logic        grant_rec;
  logic        rd_done;
  logic        wr_done;
  logic        wr_perform;
  logic        dl_wr_eff;
  logic        dl_rise;
  logic        dl_fall;
  logic        contended;

  // A request is masked during its own ack cycle (see handshake note above).
  assign play_pend  = play_req & ~play_ack;
  assign rec_pend   = rec_req & ~rec_ack;
  assign dl_wr_eff  = dl_active & dl_wr;
  assign dl_rise    = dl_active & ~dl_active_q;
  assign dl_fall    = ~dl_active & dl_active_q;
  assign wr_perform = wr_done & ~write_protect;
  // Round-robin only advances when both requesters competed, so repeated
  // contention alternates the winner regardless of uncontested traffic.
  assign contended  = (grant_play & rec_pend) | (grant_rec & play_pend);
  assign fsm_state  = state_q;

  // Next state and access decode.
  always_comb begin
    state_d    = state_q;
    grant_play = 1'b0;
    grant_rec  = 1'b0;
    rd_done    = 1'b0;
    wr_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dl_active) begin
          state_d = DL;
        end else if (play_pend && (!rec_pend || !rr_rec_q)) begin
          grant_play = 1'b1;
          state_d    = RD_WAIT;
        end else if (rec_pend) begin
          grant_rec = 1'b1;
          state_d   = WR;
        end
      end
      DL: begin
        if (!dl_active) state_d = IDLE;
      end
      RD_WAIT: begin
        // A download arriving now aborts the read; the request stays held.
        if (dl_active) begin
          state_d = DL;
        end else begin
          rd_done = 1'b1;
          state_d = IDLE;
        end
      end
      WR: begin
        if (dl_active) begin
          state_d = DL;
        end else begin
          wr_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM port: download passes straight through; otherwise the FSM drives it,
  // and when idle the address/data hold their last value with no write.
  always_comb begin
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    mem_we    = 1'b0;
    if (dl_active) begin
      mem_addr  = dl_addr;
      mem_wdata = dl_data;
      mem_we    = dl_wr & reset_n;
    end else if (grant_play) begin
      mem_addr = play_addr;
    end else if (wr_done) begin
      mem_addr  = rec_addr;
      mem_wdata = rec_data;
      mem_we    = ~write_protect;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_rec_q    <= 1'b0;
      dl_active_q <= 1'b0;
      written_q   <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 8'd0;
      play_ack    <= 1'b0;
      play_data   <= 8'd0;
      rec_ack     <= 1'b0;
      rewind      <= 1'b0;
      tape_end    <= 16'd0;
      tape_loaded <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_active_q <= dl_active;
      mem_addr_q  <= mem_addr;
      mem_wdata_q <= mem_wdata;
      play_ack    <= rd_done;
      rec_ack     <= wr_done;
      rewind      <= dl_rise;

      if (rd_done) play_data <= mem_q;
      if (contended) rr_rec_q <= grant_play;

      // A strobe in the very first download cycle must still count as written.
      if (dl_wr_eff)    written_q <= 1'b1;
      else if (dl_rise) written_q <= 1'b0;

      if (dl_rise)         tape_loaded <= 1'b0;
      else if (dl_fall)    tape_loaded <= written_q;
      else if (wr_perform) tape_loaded <= 1'b1;

      if (dl_wr_eff) begin
        tape_end <= dl_addr;
      end else if (wr_perform && ((rec_addr > tape_end) || !tape_loaded)) begin
        tape_end <= rec_addr;
      end
    end
  end

endmodule
